// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//
// Receive half of the UART. Recovers 8N1 frames (8E1 when the
// UART_RX_PARITY_EN macro is defined) from an asynchronous serial line,
// using an OVERSAMPLE x baud enable from the baud-rate generator.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> PARITY state present, even parity checked
//                      undefined -> no parity bit, parity_err_o tied low
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active low
//   baud_tick_i   one-clk enable at OVERSAMPLE x baud rate
//   rx_i          serial line, asynchronous, idle high
//   rx_data_o     last good byte, held until the next good frame
//   rx_valid_o    one-cycle pulse when rx_data_o updates
//   frame_err_o   one-cycle pulse when the stop bit is sampled low
//   parity_err_o  one-cycle pulse on parity mismatch
//   busy_o        high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE/2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t                 state_q;
    logic                   rx_meta_q;
    logic                   rx_sync_q;
    logic [TW-1:0]          tcnt_q;
    logic [BW-1:0]          bcnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q;
    logic                   frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q;
    logic                   parity_err_q;
`endif

    // Two-flop synchronizer; resets to the idle line level so that reset
    // release never looks like a start bit on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // LSB arrives first: shift right, new bit enters at the top.
    assign shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (baud_tick_i) begin
                        if (tcnt_q == T_MID) begin
                            // A line that is high again at mid-bit was a glitch.
                            tcnt_q  <= '0;
                            bcnt_q  <= '0;
                            state_q <= rx_sync_q ? S_IDLE : S_DATA;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (baud_tick_i) begin
                        if (tcnt_q == T_END) begin
                            tcnt_q  <= '0;
                            shift_q <= shift_d;
                            if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end else begin
                                bcnt_q <= bcnt_q + BW'(1);
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (baud_tick_i) begin
                        if (tcnt_q == T_END) begin
                            tcnt_q    <= '0;
                            // Even parity: data bits plus parity bit XOR to 0.
                            par_bad_q <= rx_sync_q ^ (^shift_q);
                            state_q   <= S_STOP;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end
`endif

                S_STOP: begin
                    if (baud_tick_i) begin
                        if (tcnt_q == T_END) begin
                            tcnt_q <= '0;
                            if (!rx_sync_q) begin
                                // Framing error wins; parity is not reported.
                                frame_err_q <= 1'b1;
                                state_q     <= S_BREAK;
                            end else begin
                                state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                                if (par_bad_q) begin
                                    parity_err_q <= 1'b1;
                                end else begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end
`else
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
`endif
                            end
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end

                S_BREAK: begin
                    // A held-low line must return high before the next frame.
                    tcnt_q <= '0;
                    if (rx_sync_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    tcnt_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Stop-bit sample tick relative to the tick before the start bit.
    localparam int LAT     = OS/2 + (8 + 1 + PBITS) * OS;
    // Spacing of back-to-back frames with a single stop bit.
    localparam int SPACING = (8 + 2 + PBITS) * OS;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    int tick_no     = 0;
    int valid_cnt   = 0;
    int frame_cnt   = 0;
    int par_cnt     = 0;
    int valid_tick  = 0;
    int frame_tick  = 0;
    int onehot_viol = 0;

    int start_tick;
    int t1;
    int v0;
    int f0;
    int p0;

    uart_rx_core #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick_i  (baud_tick),
        .rx_i         (rx),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One tick every four clocks, changed on the falling edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (baud_tick) tick_no <= tick_no + 1;
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt  = valid_cnt + 1;
            valid_tick = tick_no;
        end
        if (frame_err) begin
            frame_cnt  = frame_cnt + 1;
            frame_tick = tick_no;
        end
        if (parity_err) par_cnt = par_cnt + 1;
        if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1)
            onehot_viol = onehot_viol + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the rising edge that consumed the next tick.
    task automatic next_tick();
        @(posedge clk);
        while (baud_tick !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) next_tick();
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop bit; each 16 ticks.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip_par);
        rx = 1'b0;
        start_tick = tick_no;
        ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            ticks(OS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ flip_par;
        ticks(OS);
`else
        if (flip_par) rx = 1'b1;
`endif
        rx = stop_bit;
        ticks(OS);
    endtask

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset rx_data",    {24'd0, rx_data}, 32'h00);
        chk("reset rx_valid",   {31'd0, rx_valid}, 32'd0);
        chk("reset frame_err",  {31'd0, frame_err}, 32'd0);
        chk("reset parity_err", {31'd0, parity_err}, 32'd0);
        chk("reset busy",       {31'd0, busy}, 32'd0);
        rst = 1'b1;
        ticks(4);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5 valid count", valid_cnt, 1);
        chk("a5 rx_data", {24'd0, rx_data}, 32'hA5);
        chk("a5 latency", valid_tick - start_tick, LAT);
        chk("a5 frame_err count", frame_cnt, 0);
        chk("a5 busy after", {31'd0, busy}, 32'd0);

        // Framing error: 0x3C with low stop bit, then line held low
        send_frame(8'h3C, 1'b0, 1'b0);
        ticks(40);
        chk("ferr frame_err count", frame_cnt, 1);
        chk("ferr valid count", valid_cnt, 1);
        chk("ferr rx_data held", {24'd0, rx_data}, 32'hA5);
        chk("ferr latency", frame_tick - start_tick, LAT);
        chk("ferr busy while low", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        ticks(1);
        chk("ferr busy after release", {31'd0, busy}, 32'd0);
        chk("ferr no second frame_err", frame_cnt, 1);
        ticks(8);

        // Glitch: low for 4 ticks, then high
        v0 = valid_cnt;
        f0 = frame_cnt;
        rx = 1'b0;
        ticks(4);
        chk("glitch busy during", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        ticks(4);
        chk("glitch busy by tick 8", {31'd0, busy}, 32'd0);
        ticks(8);
        chk("glitch no valid", valid_cnt, v0);
        chk("glitch no frame_err", frame_cnt, f0);

        // Good frame 0x3C after glitch
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("3c rx_data", {24'd0, rx_data}, 32'h3C);
        chk("3c valid count", valid_cnt, v0 + 1);
        ticks(4);

        // Back-to-back 0x00 then 0xFF
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        t1 = valid_tick;
        chk("b2b first rx_data", {24'd0, rx_data}, 32'h00);
        send_frame(8'hFF, 1'b1, 1'b0);
        chk("b2b second rx_data", {24'd0, rx_data}, 32'hFF);
        chk("b2b valid count", valid_cnt, v0 + 2);
        chk("b2b spacing", valid_tick - t1, SPACING);
        ticks(4);

`ifdef UART_RX_PARITY_EN
        // 8E1: 0x07 has three ones, so the correct parity bit is 1
        v0 = valid_cnt;
        p0 = par_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par good rx_data", {24'd0, rx_data}, 32'h07);
        chk("par good valid count", valid_cnt, v0 + 1);
        send_frame(8'h0F, 1'b1, 1'b1);
        chk("par bad parity_err count", par_cnt, p0 + 1);
        chk("par bad rx_data held", {24'd0, rx_data}, 32'h07);
        chk("par bad valid count", valid_cnt, v0 + 1);
        ticks(4);
`endif

        // Reset in the middle of data bit 4 of 0x55
        rx = 1'b0;
        ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx = i[0] ? 1'b0 : 1'b1;
            ticks(OS);
        end
        rx = 1'b1;
        ticks(OS/2);
        chk("midframe busy before reset", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst rx_data", {24'd0, rx_data}, 32'h00);
        chk("midrst rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst parity_err", {31'd0, parity_err}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ticks(4);
        v0 = valid_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        chk("81 rx_data", {24'd0, rx_data}, 32'h81);
        chk("81 valid count", valid_cnt, v0 + 1);
        chk("81 latency", valid_tick - start_tick, LAT);
        ticks(4);

`ifndef UART_RX_PARITY_EN
        chk("parity_err never pulsed", par_cnt, 0);
`endif
        chk("pulses mutually exclusive", onehot_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
